// File: rtl/adder_share_arb_pkg.sv
// adder_share_arb_pkg: shared definitions for the time-shared adder arbiter.
//   state_t   - FSM state encoding (IDLE, SETTLE, RESP)
//   clog2     - id / counter width helper, never smaller than 1
//   slice_lo  - low bit of requester i's operand inside a packed bus
package adder_share_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int slice_lo(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/adder_share_arb_cra.sv
// cra: plain ripple-carry adder, carry-in tied to 0.
//   a, b : width-bit operands
//   s    : width+1-bit sum, carry-out at bit width
// The carry chain is long and unregistered; callers hold the operands
// stable for several clocks before sampling s.
module cra #(
    parameter int width = 8
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width:0]   s
);

    logic [width:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < width; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign s[width] = c[width];

endmodule

// File: rtl/adder_share_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req    : per-requester request
//   ptr    : index the search starts from (wraps modulo NREQ)
//   enable : when low no grant is issued
//   gnt    : one-hot (or zero) grant
//   gnt_id : index of the granted requester (0 when no grant)
module rr_arbiter
    import adder_share_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            enable,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (enable && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// adder_share_arb: one ripple-carry adder time-shared among NREQ requesters.
// Operands are registered and held for SETTLE_CYCLES clocks (multicycle
// carry path) before {carry, sum} is captured and offered on the result port.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester handshake (ready one-hot or zero)
//   req_x, req_y          : packed operands, requester i at [i*width +: width]
//   res_valid/res_ready   : result handshake
//   res_s, res_id         : sum (carry at bit width) and owning requester
//   busy                  : high whenever the FSM is not in IDLE
//   res_ovf               : signed overflow flag, only with ADDER_SHARE_ARB_OVF_EN
`ifndef WIDTH
`define WIDTH 8
`endif
module adder_share_arb
    import adder_share_arb_pkg::*;
#(
    parameter int width         = `WIDTH,
    parameter int NREQ          = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int IDW           = clog2(NREQ),
    parameter int CW            = clog2(SETTLE_CYCLES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*width-1:0] req_x,
    input  logic [NREQ*width-1:0] req_y,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [width:0]        res_s,
    output logic [IDW-1:0]        res_id,
    output logic                  busy
`ifdef ADDER_SHARE_ARB_OVF_EN
    ,
    output logic                  res_ovf
`endif
);

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   id_r;
    logic [IDW-1:0]   gnt_id;
    logic [CW-1:0]    cnt;
    logic [width-1:0] x_r, y_r;
    logic [width:0]   sum;
    logic [NREQ-1:0]  gnt;
    logic             arb_en;
    logic [width-1:0] x_arr [NREQ];
    logic [width-1:0] y_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign x_arr[i] = req_x[slice_lo(i, width) +: width];
        assign y_arr[i] = req_y[slice_lo(i, width) +: width];
    end

    // Gating with rst_n keeps req_ready low while reset is held, even
    // though state already reads IDLE.
    assign arb_en = (state == IDLE) && rst_n;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .enable (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = gnt;

    cra #(.width(width)) u_cra (
        .a (x_r),
        .b (y_r),
        .s (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            x_r       <= '0;
            y_r       <= '0;
            id_r      <= '0;
            res_s     <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef ADDER_SHARE_ARB_OVF_EN
            res_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        x_r   <= x_arr[gnt_id];
                        y_r   <= y_arr[gnt_id];
                        id_r  <= gnt_id;
                        cnt   <= CW'(SETTLE_CYCLES - 1);
                        busy  <= 1'b1;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        res_s     <= sum;
                        res_id    <= id_r;
                        res_valid <= 1'b1;
`ifdef ADDER_SHARE_ARB_OVF_EN
                        res_ovf   <= (x_r[width-1] == y_r[width-1]) &&
                                     (sum[width-1] != x_r[width-1]);
`endif
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        // Pointer moves only here, so consumer stalls never
                        // shift the fairness order.
                        rr_ptr    <= (id_r == IDW'(NREQ - 1)) ? '0 : id_r + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arb.sv
module tb_adder_share_arb;

    localparam int W = 8;
    localparam int N = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_x, req_y;
    logic           res_valid;
    logic           res_ready;
    logic [W:0]     res_s;
    logic [1:0]     res_id;
    logic           busy;
`ifdef ADDER_SHARE_ARB_OVF_EN
    logic           res_ovf;
`endif

    logic [W-1:0] xs [N];
    logic [W-1:0] ys [N];
    int total = 0;
    int bad   = 0;
    int ptr_m = 0;
    int got_id;

    always #5 clk = ~clk;

    always_comb begin
        req_x = '0;
        req_y = '0;
        for (int i = 0; i < N; i++) begin
            req_x[i*W +: W] = xs[i];
            req_y[i*W +: W] = ys[i];
        end
    end

    adder_share_arb #(.width(W), .NREQ(N), .SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_s     (res_s),
        .res_id    (res_id),
`ifdef ADDER_SHARE_ARB_OVF_EN
        .res_ovf   (res_ovf),
`endif
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first valid requester at or after the pointer.
    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Runs one transaction from grant to result handshake. Entered just after
    // a negedge with inputs already driven; leaves just after a negedge.
    task automatic serve(input int stall, input bit drop, input bit pulse1, output int rid);
        int n, id, lat;
        logic [W:0] s_exp;
        logic       ovf_exp;
        rid = -1;
        #1;
        n = 0;
        while (req_ready === '0 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        total++;
        assert (req_ready !== '0) else begin
            bad++;
            $error("FAIL grant_timeout observed=0 expected=nonzero");
        end
        if (req_ready === '0) return;
        id = model_grant(req_valid, ptr_m);
        chk("req_ready", 32'(req_ready), 32'(1 << id));
        s_exp   = {1'b0, xs[id]} + {1'b0, ys[id]};
        ovf_exp = (xs[id][W-1] == ys[id][W-1]) && (s_exp[W-1] != xs[id][W-1]);
        @(negedge clk); #1;
        chk("ready_after_accept", 32'(req_ready), 0);
        chk("busy_settle", 32'(busy), 1);
        if (drop) req_valid[id] = 1'b0;
        for (int i = 0; i < N; i++) begin
            xs[i] = W'($urandom);
            ys[i] = W'($urandom);
        end
        if (stall > 0) res_ready = 1'b0;
        lat = 1;
        while (!res_valid && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        chk("latency", lat, S + 1);
        chk("res_s", 32'(res_s), 32'(s_exp));
        chk("res_id", 32'(res_id), id);
        chk("busy_resp", 32'(busy), 1);
`ifdef ADDER_SHARE_ARB_OVF_EN
        chk("res_ovf", 32'(res_ovf), 32'(ovf_exp));
`endif
        rid = int'(res_id);
        for (int k = 0; k < stall; k++) begin
            if (pulse1) req_valid[1] = (k == 0);
            @(negedge clk); #1;
            chk("stall_valid", 32'(res_valid), 1);
            chk("stall_s", 32'(res_s), 32'(s_exp));
            chk("stall_id", 32'(res_id), id);
            chk("stall_ready", 32'(req_ready), 0);
            chk("stall_busy", 32'(busy), 1);
        end
        res_ready = 1'b1;
        @(negedge clk); #1;
        chk("res_valid_drop", 32'(res_valid), 0);
        chk("busy_idle", 32'(busy), 0);
        ptr_m = (id + 1) % N;
    endtask

    initial begin
        req_valid = '0;
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            xs[i] = '0;
            ys[i] = '0;
        end

        // Reset state, with every requester asking
        #2 rst_n = 1'b0;
        @(negedge clk);
        req_valid = '1;
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_s", 32'(res_s), 0);
        chk("rst_id", 32'(res_id), 0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;

        // Single request
        xs[0] = 8'h12; ys[0] = 8'h34; req_valid = 4'b0001;
        serve(0, 1, 0, got_id);

        // Carry out, then signed overflow case
        xs[0] = 8'hFF; ys[0] = 8'h01; req_valid = 4'b0001;
        serve(0, 1, 0, got_id);
        xs[0] = 8'h7F; ys[0] = 8'h01; req_valid = 4'b0001;
        serve(0, 1, 0, got_id);

        // Bring the pointer back to 0, then check fairness with all valid
        req_valid = 4'b1000;
        serve(0, 1, 0, got_id);
        for (int i = 0; i < N; i++) begin
            xs[i] = W'(8'h10 * (i + 1));
            ys[i] = W'(8'h03 + i);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            serve(0, 0, 0, got_id);
            chk("fair_seq", got_id, k % N);
        end
        req_valid = '0;

        // Backpressure
        req_valid = 4'b0010;
        serve(5, 1, 0, got_id);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("bp_once_valid", 32'(res_valid), 0);
            chk("bp_once_busy", 32'(busy), 0);
        end

        // Requester 1 pulses valid only while requester 0 sits in RESP
        req_valid = 4'b0001;
        serve(3, 1, 1, got_id);
        for (int k = 0; k < 4; k++) begin
            chk("wd_ready", 32'(req_ready), 0);
            chk("wd_valid", 32'(res_valid), 0);
            @(negedge clk); #1;
        end

        // Reset one cycle after accept
        xs[2] = 8'hA5; ys[2] = 8'h3C; req_valid = 4'b0100;
        #1;
        chk("rs_grant", 32'(req_ready), 32'h4);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rs_valid", 32'(res_valid), 0);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_ptr", 32'(dut.rr_ptr), 0);
        chk("rs_ready", 32'(req_ready), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("rs_hold_valid", 32'(res_valid), 0);
        end
        rst_n = 1'b1;
        ptr_m = 0;
        xs[2] = 8'hC8; ys[2] = 8'h64;
        serve(0, 1, 0, got_id);
        chk("rs_after_id", got_id, 2);

        // Randomized traffic against the reference model
        for (int r = 0; r < 12; r++) begin
            req_valid = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                xs[i] = W'($urandom);
                ys[i] = W'($urandom);
            end
            serve(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 0, got_id);
        end
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
